// File: rtl/ex_stage.sv
// EX stage: ALU, operand/destination muxing, branch target adder, and an
// iterative shift-add unsigned multiplier that stalls the front end while
// it runs. All outputs except stall come from the EX/MEM register.
//
// state  | meaning
// IDLE   | normal single-cycle execution; a valid multu starts the multiplier
// MUL    | one shift-add iteration per cycle, front end stalled
// DONE   | product in HI/LO, held multu retires as a bubble-like entry
module ex_stage #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [1:0]      wb_in,
  input  logic [2:0]      m_in,
  input  logic [3:0]      ex_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     reg1,
  input  logic [31:0]     reg2,
  input  logic [31:0]     sign_extend,
  input  logic [5:0]      funct,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  output logic            stall,
  output logic [1:0]      wb_out,
  output logic [2:0]      m_out,
  output logic            valid_out,
  output logic [31:0]     alu_result,
  output logic [31:0]     store_data,
  output logic [4:0]      dest_reg,
  output logic            zero,
  output logic [PC_W-1:0] branch_target
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [1:0]      r_wb;
  logic [2:0]      r_m;
  logic            r_valid;
  logic [31:0]     r_alu;
  logic [31:0]     r_store;
  logic [4:0]      r_dest;
  logic            r_zero;
  logic [PC_W-1:0] r_bt;

  logic            w_regdst;
  logic [1:0]      w_aluop;
  logic            w_alusrc;
  logic [31:0]     w_opb;
  logic            w_live;
  logic            w_is_multu;
  logic [31:0]     w_alu;
  logic [63:0]     w_acc_next;

  assign w_regdst   = ex_in[3];
  assign w_aluop    = ex_in[2:1];
  assign w_alusrc   = ex_in[0];
  assign w_opb      = w_alusrc ? sign_extend : reg2;
  assign w_live     = in_valid && !flush;
  assign w_is_multu = w_live && (w_aluop == 2'b10) && (funct == F_MULTU);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

  // Stall is combinational so the multu is held from the very cycle it arrives;
  // it is forced low while reset is asserted.
  assign stall = rst_n && (((r_state == S_IDLE) && w_is_multu) || (r_state == S_MUL));

  // ALU result selection; multu itself and unknown functs produce 0
  always_comb begin
    w_alu = 32'd0;
    case (w_aluop)
      2'b01: w_alu = reg1 - w_opb;
      2'b10: begin
        case (funct)
          F_ADD:   w_alu = reg1 + w_opb;
          F_SUB:   w_alu = reg1 - w_opb;
          F_AND:   w_alu = reg1 & w_opb;
          F_OR:    w_alu = reg1 | w_opb;
          F_NOR:   w_alu = ~(reg1 | w_opb);
          F_SLT:   w_alu = ($signed(reg1) < $signed(w_opb)) ? 32'd1 : 32'd0;
          F_MFHI:  w_alu = r_hi;
          F_MFLO:  w_alu = r_lo;
          default: w_alu = 32'd0;
        endcase
      end
      default: w_alu = reg1 + w_opb;
    endcase
  end

  // Multiplier FSM and HI/LO; a flush mid-multiply abandons it without touching HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_multu) begin
            r_mcand  <= {32'd0, reg1};
            r_mplier <= reg2;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_hi    <= w_acc_next[63:32];
              r_lo    <= w_acc_next[31:0];
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register: bubbles while stalled or when no live instruction is present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb    <= 2'd0;
      r_m     <= 3'd0;
      r_valid <= 1'b0;
      r_alu   <= 32'd0;
      r_store <= 32'd0;
      r_dest  <= 5'd0;
      r_zero  <= 1'b0;
      r_bt    <= '0;
    end else begin
      r_alu   <= w_alu;
      r_zero  <= (w_alu == 32'd0);
      r_store <= reg2;
      r_dest  <= w_regdst ? rd : rt;
      r_bt    <= pc_in + sign_extend[PC_W-1:0];
      if (stall || !w_live) begin
        r_valid <= 1'b0;
        r_wb    <= 2'd0;
        r_m     <= 3'd0;
      end else if (r_state == S_DONE) begin
        r_valid <= 1'b1;
        r_wb    <= 2'd0;
        r_m     <= 3'd0;
      end else begin
        r_valid <= 1'b1;
        r_wb    <= wb_in;
        r_m     <= m_in;
      end
    end
  end

  assign wb_out        = r_wb;
  assign m_out         = r_m;
  assign valid_out     = r_valid;
  assign alu_result    = r_alu;
  assign store_data    = r_store;
  assign dest_reg      = r_dest;
  assign zero          = r_zero;
  assign branch_target = r_bt;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors feed a scoreboard queue; a monitor
// pops and compares on every valid_out. Stall length, flush abort and
// asynchronous reset are checked directly by the driver.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [3:0]  ex_in;
  logic [7:0]  pc_in;
  logic [31:0] reg1, reg2, sign_extend;
  logic [5:0]  funct;
  logic [4:0]  rt, rd;
  logic        stall, valid_out, zero;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest_reg;
  logic [7:0]  branch_target;

  ex_stage #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in), .pc_in(pc_in),
    .reg1(reg1), .reg2(reg2), .sign_extend(sign_extend), .funct(funct),
    .rt(rt), .rd(rd), .stall(stall), .wb_out(wb_out), .m_out(m_out),
    .valid_out(valid_out), .alu_result(alu_result), .store_data(store_data),
    .dest_reg(dest_reg), .zero(zero), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        chk_data;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] alu;
    logic        z;
    logic [4:0]  dst;
    logic [7:0]  bt;
    logic [31:0] sd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got === req) n_pass++;
    else $display("FAIL %s got=%h required=%h", nm, got, req);
  endtask

  // Monitor: every presented result must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output got alu=%h wb=%b m=%b required no valid_out",
                   alu_result, wb_out, m_out);
        end else begin
          e = exp_q.pop_front();
          if (e.chk_data)
            chk(e.name, {wb_out, m_out, alu_result, zero, dest_reg, branch_target, store_data},
                {e.wb, e.m, e.alu, e.z, e.dst, e.bt, e.sd});
          else
            chk(e.name, {59'd0, wb_out, m_out}, {59'd0, e.wb, e.m});
        end
      end
    end
  end

  task automatic drive(input logic v, input logic f, input logic [3:0] ex, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                       input logic [7:0] pc, input logic [4:0] t, input logic [4:0] d,
                       input logic [1:0] wb, input logic [2:0] m);
    in_valid = v; flush = f; ex_in = ex; funct = fn; reg1 = a; reg2 = b;
    sign_extend = se; pc_in = pc; rt = t; rd = d; wb_in = wb; m_in = m;
  endtask

  // One valid instruction with a hand-computed ALU result; the scoreboard
  // entry derives store/dest/target/zero from the stated field rules.
  task automatic send(input string nm, input logic [3:0] ex, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                      input logic [7:0] pc, input logic [4:0] t, input logic [4:0] d,
                      input logic [1:0] wb, input logic [2:0] m, input logic [31:0] exp_alu);
    exp_t e;
    drive(1'b1, 1'b0, ex, fn, a, b, se, pc, t, d, wb, m);
    e.name = nm; e.chk_data = 1'b1; e.wb = wb; e.m = m; e.alu = exp_alu;
    e.z = (exp_alu == 32'd0); e.dst = ex[3] ? d : t; e.bt = pc + se[7:0]; e.sd = b;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic bubble(input logic v, input logic f);
    drive(v, f, 4'b1100, 6'h20, 32'd1, 32'd2, 32'd0, 8'h40, 5'd1, 5'd2, 2'b11, 3'b111);
    @(posedge clk); #1;
  endtask

  task automatic do_multu(input string nm, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n = 0;
    drive(1'b1, 1'b0, 4'b1100, 6'h19, a, b, 32'd0, 8'h50, 5'd1, 5'd2, 2'b10, 3'b000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) n++;
      else break;
    end
    chk({nm, "_stall_cycles"}, 64'(n), 64'd33);
    e.name = {nm, "_retire"}; e.chk_data = 1'b0; e.wb = 2'd0; e.m = 3'd0;
    e.alu = 0; e.z = 0; e.dst = 0; e.bt = 0; e.sd = 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  localparam logic [3:0] EX_R    = 4'b1100;
  localparam logic [3:0] EX_BEQ  = 4'b0010;
  localparam logic [3:0] EX_ADDI = 4'b0001;
  localparam logic [3:0] EX_A11  = 4'b0110;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 6'd0, 0, 0, 0, 8'd0, 5'd0, 5'd0, 2'd0, 3'd0);
    #12;
    chk("reset_outputs", {32'd0, stall, wb_out, m_out, valid_out, zero, dest_reg, branch_target},
        64'd0);
    chk("reset_data", {alu_result, store_data}, 64'd0);
    rst_n = 1'b1;

    send("sub_rtype", EX_R, 6'h22, 32'd5, 32'd7, 32'd0, 8'h20, 5'd3, 5'd9, 2'b10, 3'b000, 32'hFFFFFFFE);
    send("beq_sub", EX_BEQ, 6'h00, 32'h1234, 32'h1234, 32'hFFFFFFFC, 8'h10, 5'd4, 5'd8, 2'b00, 3'b001, 32'd0);
    send("slt_signed", EX_R, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'd0, 8'h00, 5'd5, 5'd6, 2'b10, 3'b000, 32'd1);
    send("addi_wrap", EX_ADDI, 6'h00, 32'hFFFFFFFF, 32'd9, 32'd2, 8'hFF, 5'd7, 5'd1, 2'b11, 3'b010, 32'd1);
    send("and", EX_R, 6'h24, 32'h0000F0F0, 32'h00000FF0, 32'd0, 8'h01, 5'd1, 5'd2, 2'b10, 3'b000, 32'h000000F0);
    send("or", EX_R, 6'h25, 32'h0000F000, 32'h0000000F, 32'd0, 8'h02, 5'd1, 5'd3, 2'b10, 3'b000, 32'h0000F00F);
    send("nor", EX_R, 6'h27, 32'd0, 32'd0, 32'd0, 8'h03, 5'd1, 5'd4, 2'b10, 3'b000, 32'hFFFFFFFF);
    send("add_wrap", EX_R, 6'h20, 32'h7FFFFFFF, 32'd1, 32'd0, 8'h04, 5'd1, 5'd5, 2'b10, 3'b000, 32'h80000000);
    send("bad_funct", EX_R, 6'h03, 32'd11, 32'd22, 32'd0, 8'h05, 5'd1, 5'd6, 2'b10, 3'b000, 32'd0);
    send("aluop11_add", EX_A11, 6'h22, 32'd2, 32'd3, 32'h00000080, 8'h90, 5'd12, 5'd13, 2'b01, 3'b100, 32'd5);
    bubble(1'b0, 1'b0);
    bubble(1'b1, 1'b1);

    do_multu("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF);
    send("mfhi_max", EX_R, 6'h10, 32'd0, 32'd0, 32'd0, 8'h60, 5'd1, 5'd10, 2'b10, 3'b000, 32'hFFFFFFFE);
    send("mflo_max", EX_R, 6'h12, 32'd0, 32'd0, 32'd0, 8'h61, 5'd1, 5'd11, 2'b10, 3'b000, 32'h00000001);

    do_multu("multu_3x4", 32'd3, 32'd4);
    send("mflo_12", EX_R, 6'h12, 32'd0, 32'd0, 32'd0, 8'h62, 5'd1, 5'd11, 2'b10, 3'b000, 32'd12);

    // New multu aborted by flush partway through MUL
    drive(1'b1, 1'b0, EX_R, 6'h19, 32'd5, 32'd6, 32'd0, 8'h50, 5'd1, 5'd2, 2'b10, 3'b000);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, EX_R, 6'h12, 32'd0, 32'd0, 32'd0, 8'h63, 5'd1, 5'd11, 2'b10, 3'b000);
    @(negedge clk);
    chk("flush_stall_drop", {63'd0, stall}, 64'd0);
    #4;
    send("mflo_after_flush", EX_R, 6'h12, 32'd0, 32'd0, 32'd0, 8'h63, 5'd1, 5'd11, 2'b10, 3'b000, 32'd12);
    send("mfhi_after_flush", EX_R, 6'h10, 32'd0, 32'd0, 32'd0, 8'h64, 5'd1, 5'd10, 2'b10, 3'b000, 32'd0);

    // Reset in the middle of a multiply
    drive(1'b1, 1'b0, EX_R, 6'h19, 32'd7, 32'd9, 32'd0, 8'h50, 5'd1, 5'd2, 2'b10, 3'b000);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 6'd0, 0, 0, 0, 8'd0, 5'd0, 5'd0, 2'd0, 3'd0);
    #1;
    chk("midmul_reset_outputs", {32'd0, stall, wb_out, m_out, valid_out, zero, dest_reg, branch_target},
        64'd0);
    chk("midmul_reset_data", {alu_result, store_data}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send("mfhi_after_reset", EX_R, 6'h10, 32'd0, 32'd0, 32'd0, 8'h70, 5'd1, 5'd10, 2'b10, 3'b000, 32'd0);
    send("mflo_after_reset", EX_R, 6'h12, 32'd0, 32'd0, 32'd0, 8'h71, 5'd1, 5'd11, 2'b10, 3'b000, 32'd0);

    bubble(1'b0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
